// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point adder scheduler.
package fp_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned WDOG_W = 8;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Operand pair handed to the shared adder core.
    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_operands_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one floating-point adder core among NUM_REQ requesters with
// round-robin arbitration, start/done sequencing and a watchdog abort.
module fp_add_scheduler
    import fp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_sum,
    output logic                    rsp_err,
    output logic                    add_start,
    output logic [FP_W-1:0]         add_a,
    output logic [FP_W-1:0]         add_b,
    input  logic                    add_done,
    input  logic [FP_W-1:0]         add_sum,
    output logic                    busy
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [WDOG_W-1:0]  wdog_q;
    logic [WDOG_W-1:0]  wdog_d;
    fp_operands_t       ops_q;
    fp_operands_t       sel_ops;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               handshake;
    logic               load_ops;
    logic               load_rsp;
    logic [FP_W-1:0]    rsp_sum_d;
    logic               rsp_err_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // Grants are offered only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_q == ST_IDLE) && !reset) begin
            req_ready = arb_grant;
        end
    end

    assign handshake = |(req_valid & req_ready);

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_ops = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_ops.a = req_a[i*FP_W +: FP_W];
                sel_ops.b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    // Next-state, watchdog and load-enable logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        wdog_d    = wdog_q;
        load_ops  = 1'b0;
        load_rsp  = 1'b0;
        rsp_sum_d = add_sum;
        rsp_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    load_ops = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A done strobe on the last watchdog cycle still wins.
                if (add_done) begin
                    load_rsp  = 1'b1;
                    rsp_sum_d = add_sum;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    load_rsp  = 1'b1;
                    rsp_sum_d = FP_QNAN;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = ID_W'((32'(rsp_id) + 32'd1) % NUM_REQ);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            wdog_q    <= '0;
            add_start <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            wdog_q    <= wdog_d;
            add_start <= (state_d == ST_ISSUE);
            rsp_valid <= (state_d == ST_RESP);
            busy      <= (state_d != ST_IDLE);
        end
    end

    // Operand and response holding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ops_q   <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (load_ops) begin
                ops_q  <= sel_ops;
                rsp_id <= arb_id;
            end
            if (load_rsp) begin
                rsp_sum <= rsp_sum_d;
                rsp_err <= rsp_err_d;
            end
        end
    end

    assign add_a = ops_q.a;
    assign add_b = ops_q.b;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler with a behavioural adder core model.
module tb_fp_add_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_err;
    logic                  add_start;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic                  add_done = 1'b0;
    logic [31:0]           add_sum  = 32'd0;
    logic                  busy;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int model_ptr = 0;
    int core_lat  = 4;
    int core_rem  = 0;
    bit inject_done = 1'b0;
    logic [31:0] core_a = 32'd0;
    logic [31:0] core_b = 32'd0;

    always #5 clock = ~clock;

    fp_add_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_done  (add_done),
        .add_sum   (add_sum),
        .busy      (busy)
    );

    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = 11'(32'(x[30:23]) + 32'd896);
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(135, 120));
        return r;
    endfunction

    // Adder core model: done strobe L cycles after the start pulse was seen.
    always @(negedge clock) begin
        add_done = inject_done;
        if (reset) begin
            core_rem = 0;
        end else if (add_start === 1'b1) begin
            core_rem = core_lat;
            core_a   = add_a;
            core_b   = add_b;
        end else if (core_rem > 0) begin
            core_rem = core_rem - 1;
            if (core_rem == 0) begin
                add_done = 1'b1;
                add_sum  = fp_add(core_a, core_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "hung");
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // One full transaction; expectations come from the round-robin and timing rules.
    task automatic run_op(input int lat, input logic [NUM_REQ-1:0] mask, input int bp,
                          input bit keep, output int got_id);
        int w;
        int idx;
        int ecyc;
        int starts;
        bit eerr;
        logic [NUM_REQ-1:0] eg;
        logic [31:0] ea, eb, esum, hsum;
        logic [ID_W-1:0] hid;
        core_lat = lat;
        if (!keep) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a[i*32 +: 32] = rand_fp();
                req_b[i*32 +: 32] = rand_fp();
            end
        end
        rsp_ready = (bp == 0);
        req_valid = mask;
        #1;
        w = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (model_ptr + k) % NUM_REQ;
            if (w < 0 && mask[idx]) w = idx;
        end
        eg = NUM_REQ'(1) << w;
        checks++;
        if (req_ready !== eg) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b (mask %b)", req_ready, eg, mask);
        end
        ea   = req_a[w*32 +: 32];
        eb   = req_b[w*32 +: 32];
        eerr = (lat > TIMEOUT);
        esum = eerr ? QNAN : fp_add(ea, eb);
        ecyc = eerr ? TIMEOUT + 2 : lat + 2;
        cyc  = 0;
        step();
        checks++;
        if (add_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL issue: add_start=%b busy=%b expected 1 1", add_start, busy);
        end
        checks++;
        if ({add_a, add_b} !== {ea, eb}) begin
            errors++;
            $display("FAIL operands: add_a=%h add_b=%h expected %h %h", add_a, add_b, ea, eb);
        end
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*32 +: 32] = $urandom;
            req_b[i*32 +: 32] = $urandom;
        end
        starts = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            step();
            if (add_start === 1'b1) starts++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || cyc != ecyc) begin
            errors++;
            $display("FAIL latency: rsp_valid=%b at cycle %0d expected cycle %0d", rsp_valid, cyc, ecyc);
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL start_pulse: %0d extra add_start cycles expected 0", starts);
        end
        checks++;
        if (rsp_id !== ID_W'(w)) begin
            errors++;
            $display("FAIL rsp_id: got %0d expected %0d", rsp_id, w);
        end
        checks++;
        if (rsp_sum !== esum || rsp_err !== eerr) begin
            errors++;
            $display("FAIL result: sum=%h err=%b expected %h %b", rsp_sum, rsp_err, esum, eerr);
        end
        checks++;
        if ({add_a, add_b} !== {ea, eb}) begin
            errors++;
            $display("FAIL operand_hold: add_a=%h add_b=%h expected %h %h", add_a, add_b, ea, eb);
        end
        hid  = rsp_id;
        hsum = rsp_sum;
        if (bp > 0) begin
            req_valid = mask;
            for (int k = 0; k < bp; k++) begin
                step();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== hid || rsp_sum !== hsum || req_ready !== '0) begin
                    errors++;
                    $display("FAIL backpressure: valid=%b id=%0d sum=%h ready=%b expected 1 %0d %h 0000",
                             rsp_valid, rsp_id, rsp_sum, req_ready, hid, hsum);
                end
            end
            rsp_ready = 1'b1;
        end
        step();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
        model_ptr = (w + 1) % NUM_REQ;
        got_id = w;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || add_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctrl: ready=%b rsp_valid=%b add_start=%b busy=%b expected all 0",
                     tag, req_ready, rsp_valid, add_start, busy);
        end
        checks++;
        if (rsp_id !== '0 || rsp_sum !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsp: id=%0d sum=%h err=%b expected 0 0 0", tag, rsp_id, rsp_sum, rsp_err);
        end
        checks++;
        if (add_a !== 32'd0 || add_b !== 32'd0) begin
            errors++;
            $display("FAIL %s_operands: add_a=%h add_b=%h expected 0 0", tag, add_a, add_b);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        rsp_ready   = 1'b0;
        req_valid   = '1;
        inject_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*32 +: 32] = rand_fp();
            req_b[i*32 +: 32] = rand_fp();
        end
        step();
        step();
        check_reset_outputs("reset");
        reset     = 1'b0;
        req_valid = '0;
        model_ptr = 0;
    endtask

    task automatic test_single_request();
        int id;
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        run_op(4, 4'b0001, 0, 1'b1, id);
        checks++;
        if (rsp_sum !== 32'h4040_0000 || id != 0) begin
            errors++;
            $display("FAIL single_sum: sum=%h id=%0d expected 40400000 0", rsp_sum, id);
        end
    endtask

    task automatic test_round_robin();
        int id;
        logic [NUM_REQ-1:0] seen;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_ptr = 0;
        seen = '0;
        for (int k = 0; k < 5; k++) begin
            run_op(int'($urandom_range(6, 1)), 4'b1111, 0, 1'b0, id);
            checks++;
            if (id != k % 4) begin
                errors++;
                $display("FAIL rr_order: op %0d granted %0d expected %0d", k, id, k % 4);
            end
            if (k < 4) seen = seen | (NUM_REQ'(1) << id);
        end
        checks++;
        if (seen !== 4'b1111) begin
            errors++;
            $display("FAIL rr_fairness: granted set %b expected 1111", seen);
        end
    endtask

    task automatic test_backpressure();
        int id;
        run_op(3, 4'b0110, 10, 1'b0, id);
        run_op(2, 4'b1111, 0, 1'b0, id);
    endtask

    task automatic test_watchdog();
        int id;
        run_op(TIMEOUT + 4, 4'b0100, 0, 1'b0, id);
        checks++;
        if (rsp_sum !== QNAN || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_hold: sum=%h err=%b expected %h 1", rsp_sum, rsp_err, QNAN);
        end
        for (int k = 0; k < 6; k++) begin
            inject_done = (k == 3);
            step();
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stale_done: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
            end
        end
        inject_done = 1'b0;
    endtask

    task automatic test_done_final();
        int id;
        run_op(TIMEOUT, 4'b1000, 0, 1'b0, id);
        run_op(TIMEOUT + 1, 4'b0001, 0, 1'b0, id);
    endtask

    task automatic test_reset_mid_wait();
        int id;
        core_lat  = 6;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_ptr = 0;
        check_reset_outputs("midreset");
        for (int k = 0; k < 4; k++) begin
            inject_done = (k == 1);
            step();
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_done: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
            end
        end
        inject_done = 1'b0;
        run_op(3, 4'b1111, 0, 1'b0, id);
        checks++;
        if (id != 0) begin
            errors++;
            $display("FAIL post_reset_ptr: granted %0d expected 0", id);
        end
    endtask

    task automatic test_random();
        int id;
        for (int k = 0; k < 12; k++) begin
            run_op(int'($urandom_range(TIMEOUT + 3, 1)), NUM_REQ'($urandom_range(15, 1)),
                   int'($urandom_range(3, 0)), 1'b0, id);
        end
    endtask

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        test_reset();
        test_single_request();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_done_final();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
